// File: rtl/ascon_pkg.sv
// ---- ascon_pkg : shared state type and defaults for the ASCON I/O sequencer ----
// ---- Revision 1.0 ----
`default_nettype none

package ascon_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_TAG_W  = 128;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/ascon_io_sequencer.sv
// ---- ascon_io_sequencer : buffers a host message, feeds the ASCON core, returns C + tag ----
// ---- Revision 1.0 ----
`default_nettype none

module ascon_io_sequencer
  import ascon_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int TAG_W        = DEF_TAG_W,
  parameter int NB_PT_BLOCKS = 4
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              start_o,
  output logic              data_valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  block_idx_o,
  input  logic              ad_ack_i,
  input  logic              cipher_valid_i,
  input  logic [DATA_W-1:0] cipher_i,
  input  logic              end_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int               DEPTH     = 1 << IDX_W;
  localparam logic [IDX_W-1:0] NB_IDX    = IDX_W'(NB_PT_BLOCKS);
  localparam logic [IDX_W:0]   NB_BEAT   = (IDX_W+1)'(NB_PT_BLOCKS);
  localparam logic [IDX_W:0]   LAST_BEAT = (IDX_W+1)'(NB_PT_BLOCKS + 1);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic [IDX_W:0]    beat_q, beat_d;
  logic [DATA_W-1:0] in_buf_q  [DEPTH];
  logic [DATA_W-1:0] in_buf_d  [DEPTH];
  logic [DATA_W-1:0] cip_buf_q [DEPTH];
  logic [DATA_W-1:0] cip_buf_d [DEPTH];
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              err_q, err_d;

  logic accept_in;
  logic load_done;
  logic beat_acc;
  logic drain_done;

  assign accept_in  = (state_q == LOAD) && in_valid_i;
  assign load_done  = accept_in && (wr_cnt_q == NB_IDX);
  assign beat_acc   = (state_q == DRAIN) && out_ready_i;
  assign drain_done = beat_acc && (beat_q == LAST_BEAT);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_done)  state_d = START;
      START:                   state_d = RUN;
      RUN:     if (end_i)      state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = LOAD;
      default:                 state_d = LOAD;
    endcase
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    idx_d     = idx_q;
    cap_cnt_d = cap_cnt_q;
    beat_d    = beat_q;
    in_buf_d  = in_buf_q;
    cip_buf_d = cip_buf_q;
    tag_d     = tag_q;
    err_d     = err_q;

    if (accept_in) begin
      in_buf_d[wr_cnt_q] = in_data_i;
      if (!load_done) wr_cnt_d = wr_cnt_q + 1'b1;
    end

    // Fresh message: clear the error and any ciphertext left from the previous one
    if (load_done) begin
      err_d     = 1'b0;
      idx_d     = '0;
      cap_cnt_d = '0;
      cip_buf_d = '{default: '0};
    end

    if (state_q == RUN) begin
      if (ad_ack_i) begin
        if (idx_q == '0) idx_d = 1'b1;
        else             err_d = 1'b1;
        if (cipher_valid_i) err_d = 1'b1;
      end else if (cipher_valid_i) begin
        if (idx_q == '0 || cap_cnt_q == NB_IDX) begin
          err_d = 1'b1;
        end else begin
          cip_buf_d[cap_cnt_q] = cipher_i;
          cap_cnt_d            = cap_cnt_q + 1'b1;
          if (idx_q != NB_IDX) idx_d = idx_q + 1'b1;
        end
      end
      // cap_cnt_d already includes a ciphertext arriving alongside end_i
      if (end_i) begin
        tag_d  = tag_i;
        beat_d = '0;
        if (cap_cnt_d != NB_IDX) err_d = 1'b1;
      end
    end

    if (drain_done) begin
      wr_cnt_d = '0;
      idx_d    = '0;
      beat_d   = '0;
    end else if (beat_acc) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_cnt_q  <= '0;
      idx_q     <= '0;
      cap_cnt_q <= '0;
      beat_q    <= '0;
      in_buf_q  <= '{default: '0};
      cip_buf_q <= '{default: '0};
      tag_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      idx_q     <= idx_d;
      cap_cnt_q <= cap_cnt_d;
      beat_q    <= beat_d;
      in_buf_q  <= in_buf_d;
      cip_buf_q <= cip_buf_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    in_ready_o   = (state_q == LOAD);
    start_o      = (state_q == START);
    busy_o       = (state_q != LOAD);
    data_valid_o = (state_q == RUN) && (idx_q == '0);
    data_o       = '0;
    block_idx_o  = idx_q;
    out_valid_o  = (state_q == DRAIN);
    out_last_o   = (state_q == DRAIN) && (beat_q == LAST_BEAT);
    out_data_o   = '0;
    err_o        = err_q;

    if (state_q == START || state_q == RUN) data_o = in_buf_q[idx_q];

    // Beats 0..NB-1 carry ciphertext, then tag high half, then tag low half
    if (state_q == DRAIN) begin
      if (beat_q < NB_BEAT)       out_data_o = cip_buf_q[beat_q[IDX_W-1:0]];
      else if (beat_q == NB_BEAT) out_data_o = tag_q[TAG_W-1 -: DATA_W];
      else                        out_data_o = tag_q[DATA_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ascon_io_sequencer.sv
// ---- tb_ascon_io_sequencer : randomized, model-checked bench for ascon_io_sequencer ----
// ---- Revision 1.0 ----
`default_nettype none

module tb_ascon_io_sequencer;

  localparam int DW = 64;
  localparam int TW = 128;
  localparam int NB = 4;

  logic          clock_i        = 1'b0;
  logic          resetb_i       = 1'b0;
  logic          in_valid_i     = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i      = '0;
  logic          start_o;
  logic          data_valid_o;
  logic [DW-1:0] data_o;
  logic [2:0]    block_idx_o;
  logic          ad_ack_i       = 1'b0;
  logic          cipher_valid_i = 1'b0;
  logic [DW-1:0] cipher_i       = '0;
  logic          end_i          = 1'b0;
  logic [TW-1:0] tag_i          = '0;
  logic          out_valid_o;
  logic          out_ready_i    = 1'b0;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          err_o;

  always #5 clock_i = ~clock_i;

  ascon_io_sequencer #(.DATA_W(DW), .TAG_W(TW), .NB_PT_BLOCKS(NB)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .start_o(start_o), .data_valid_o(data_valid_o), .data_o(data_o), .block_idx_o(block_idx_o),
    .ad_ack_i(ad_ack_i), .cipher_valid_i(cipher_valid_i), .cipher_i(cipher_i),
    .end_i(end_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 collecting, 1 launching, 2 processing, 3 returning
  int            m_phase;
  int            m_wcnt;
  int            m_beat;
  bit            m_ad_done;
  bit            m_err;
  logic [DW-1:0] m_msg [0:NB];
  logic [DW-1:0] m_caps [$];
  logic [TW-1:0] m_tag;

  logic [DW-1:0] hs_data [$];
  bit            hs_last [$];
  int            start_cnt = 0;

  task automatic model_reset();
    m_phase = 0; m_wcnt = 0; m_beat = 0; m_ad_done = 0; m_err = 0; m_tag = '0;
    m_caps.delete();
    for (int i = 0; i <= NB; i++) m_msg[i] = '0;
  endtask

  task automatic model_step();
    case (m_phase)
      0: if (in_valid_i) begin
        m_msg[m_wcnt] = in_data_i;
        if (m_wcnt == NB) begin
          m_phase = 1; m_err = 0; m_ad_done = 0; m_caps.delete();
        end else m_wcnt++;
      end
      1: m_phase = 2;
      2: begin
        if (ad_ack_i) begin
          if (!m_ad_done) m_ad_done = 1; else m_err = 1;
          if (cipher_valid_i) m_err = 1;
        end else if (cipher_valid_i) begin
          if (!m_ad_done || m_caps.size() == NB) m_err = 1;
          else m_caps.push_back(cipher_i);
        end
        if (end_i) begin
          m_tag = tag_i; m_beat = 0; m_phase = 3;
          if (m_caps.size() < NB) m_err = 1;
        end
      end
      default: if (out_ready_i) begin
        if (m_beat == NB + 1) begin m_phase = 0; m_wcnt = 0; m_ad_done = 0; end
        else m_beat++;
      end
    endcase
  endtask

  function automatic int exp_idx();
    if (m_phase < 2 || !m_ad_done) return 0;
    return (m_caps.size() + 1 > NB) ? NB : m_caps.size() + 1;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input int b);
    if (b < NB) return (b < m_caps.size()) ? m_caps[b] : '0;
    if (b == NB) return m_tag[TW-1:DW];
    return m_tag[DW-1:0];
  endfunction

  always @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) model_reset();
    else begin
      if (out_valid_o && out_ready_i) begin
        hs_data.push_back(out_data_o);
        hs_last.push_back(out_last_o);
      end
      if (start_o) start_cnt++;
      model_step();
    end
  end

  always @(posedge clock_i) begin
    #2;
    chk("in_ready",   128'(in_ready_o),   128'(m_phase == 0));
    chk("start",      128'(start_o),      128'(m_phase == 1));
    chk("busy",       128'(busy_o),       128'(m_phase != 0));
    chk("data_valid", 128'(data_valid_o), 128'(m_phase == 2 && !m_ad_done));
    chk("data",       128'(data_o),       128'((m_phase == 1 || m_phase == 2) ? m_msg[exp_idx()] : '0));
    chk("block_idx",  128'(block_idx_o),  128'(exp_idx()));
    chk("out_valid",  128'(out_valid_o),  128'(m_phase == 3));
    chk("out_data",   128'(out_data_o),   128'((m_phase == 3) ? exp_beat(m_beat) : '0));
    chk("out_last",   128'(out_last_o),   128'(m_phase == 3 && m_beat == NB + 1));
    chk("err",        128'(err_o),        128'(m_err));
  end

  logic [DW-1:0] msg_w [0:NB];
  logic [TW-1:0] cur_tag;

  task automatic clear_rec();
    hs_data.delete(); hs_last.delete(); start_cnt = 0;
  endtask

  task automatic send_all(input bit gaps);
    for (int i = 0; i <= NB; i++) begin
      int n = 0;
      logic acc;
      if (gaps) begin
        in_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock_i);
      end
      in_valid_i = 1'b1; in_data_i = msg_w[i];
      do begin acc = in_ready_o; @(negedge clock_i); n++; end while (!acc && n < 200);
      chk("load_accept", 128'(acc), 128'(1));
    end
    in_valid_i = 1'b0;
  endtask

  task automatic core(input int n_ciph, input int ad_dly, input int gap,
                      input bit end_with_last, input bit do_end);
    int n = 0;
    while (!start_o && n < 50) begin @(negedge clock_i); n++; end
    chk("start_seen", 128'(start_o), 128'(1));
    @(negedge clock_i);
    repeat (ad_dly) @(negedge clock_i);
    ad_ack_i = 1'b1; @(negedge clock_i); ad_ack_i = 1'b0;
    for (int k = 1; k <= n_ciph; k++) begin
      repeat (gap) @(negedge clock_i);
      cipher_valid_i = 1'b1;
      cipher_i = msg_w[(k <= NB) ? k : NB] ^ 64'hFF;
      if (do_end && end_with_last && k == n_ciph) begin end_i = 1'b1; tag_i = cur_tag; end
      @(negedge clock_i);
      cipher_valid_i = 1'b0; end_i = 1'b0;
    end
    if (do_end && !(end_with_last && n_ciph > 0)) begin
      repeat (gap) @(negedge clock_i);
      end_i = 1'b1; tag_i = cur_tag; @(negedge clock_i); end_i = 1'b0;
    end
  endtask

  task automatic drain(input int mode, input bit hold_in);
    int n = 0;
    bit done = 0;
    bit stalled = 0;
    logic [DW-1:0] pd = '0;
    bit pl = 0;
    while (!done && n < 400) begin
      if (stalled) begin
        chk("stall_data", 128'(out_data_o), 128'(pd));
        chk("stall_last", 128'(out_last_o), 128'(pl));
      end
      case (mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = (n % 2 == 0);
        default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (hold_in && out_last_o) in_valid_i = 1'b0;
      stalled = out_valid_o && !out_ready_i;
      pd = out_data_o; pl = out_last_o;
      done = out_valid_o && out_ready_i && out_last_o;
      @(negedge clock_i); n++;
    end
    out_ready_i = 1'b0; in_valid_i = 1'b0;
    chk("drain_done", 128'(done), 128'(1));
  endtask

  task automatic check_result(input string nm, input int n_good, input bit exp_err);
    chk({nm, "_nbeats"}, 128'(hs_data.size()), 128'(NB + 2));
    for (int b = 0; b < NB + 2 && b < hs_data.size(); b++) begin
      logic [DW-1:0] e;
      if (b < NB)       e = (b < n_good) ? (msg_w[b+1] ^ 64'hFF) : '0;
      else if (b == NB) e = cur_tag[TW-1:DW];
      else              e = cur_tag[DW-1:0];
      chk({nm, "_beat"}, 128'(hs_data[b]), 128'(e));
      chk({nm, "_last"}, 128'(hs_last[b]), 128'(b == NB + 1));
    end
    chk({nm, "_err"},   128'(err_o),     128'(exp_err));
    chk({nm, "_start"}, 128'(start_cnt), 128'(1));
    chk({nm, "_ready"}, 128'(in_ready_o), 128'(1));
  endtask

  task automatic nominal_msg();
    msg_w[0] = 64'h0123456789ABCDEF;
    for (int i = 1; i <= NB; i++) msg_w[i] = 64'(i);
    cur_tag = {16{8'hA5}};
  endtask

  task automatic random_msg();
    for (int i = 0; i <= NB; i++) msg_w[i] = {$urandom, $urandom};
    cur_tag = {$urandom, $urandom, $urandom, $urandom};
  endtask

  logic [DW-1:0] s1_exp [6];

  initial begin
    s1_exp = '{64'hFE, 64'hFD, 64'hFC, 64'hFB, 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5};
    repeat (3) @(negedge clock_i);
    resetb_i = 1'b1;
    @(negedge clock_i);
    chk("rst_in_ready",  128'(in_ready_o),  128'(1));
    chk("rst_busy",      128'(busy_o),      128'(0));
    chk("rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("rst_err",       128'(err_o),       128'(0));

    // Nominal message with hand-computed results
    nominal_msg(); clear_rec();
    send_all(0); core(NB, 13, 12, 0, 1); drain(0, 0);
    check_result("s1", NB, 0);
    for (int b = 0; b < 6 && b < hs_data.size(); b++)
      chk("s1_literal", 128'(hs_data[b]), 128'(s1_exp[b]));
    @(negedge clock_i);

    // Backpressure on the result port
    random_msg(); cur_tag = 128'h0011223344556677_8899AABBCCDDEEFF; clear_rec();
    send_all(1); core(NB, 3, 2, 0, 1); drain(1, 0);
    check_result("s2", NB, 0);
    if (hs_data.size() == 6) begin
      chk("s2_tag_hi", 128'(hs_data[4]), 128'(64'h0011223344556677));
      chk("s2_tag_lo", 128'(hs_data[5]), 128'(64'h8899AABBCCDDEEFF));
    end
    @(negedge clock_i);

    // Surplus ciphertext strobe
    random_msg(); clear_rec();
    send_all(0); core(NB + 1, 2, 1, 0, 1); drain(0, 0);
    check_result("s3", NB, 1);
    @(negedge clock_i);

    // Early end after two ciphertexts
    random_msg(); clear_rec();
    send_all(0); core(2, 1, 3, 0, 1); drain(0, 0);
    check_result("s4", 2, 1);
    @(negedge clock_i);

    // Reset mid-run, then a clean nominal message
    random_msg(); clear_rec();
    send_all(0); core(2, 4, 2, 0, 0);
    resetb_i = 1'b0;
    #1;
    chk("s5_in_ready",   128'(in_ready_o),   128'(1));
    chk("s5_busy",       128'(busy_o),       128'(0));
    chk("s5_start",      128'(start_o),      128'(0));
    chk("s5_data_valid", 128'(data_valid_o), 128'(0));
    chk("s5_data",       128'(data_o),       128'(0));
    chk("s5_idx",        128'(block_idx_o),  128'(0));
    chk("s5_out_valid",  128'(out_valid_o),  128'(0));
    chk("s5_out_data",   128'(out_data_o),   128'(0));
    chk("s5_out_last",   128'(out_last_o),   128'(0));
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(negedge clock_i);
    nominal_msg(); clear_rec();
    send_all(0); core(NB, 13, 12, 0, 1); drain(0, 0);
    check_result("s5", NB, 0);
    @(negedge clock_i);

    // Host keeps pushing words while the message is in flight
    random_msg(); clear_rec();
    send_all(0);
    in_valid_i = 1'b1; in_data_i = 64'hBAD0BAD0BAD0BAD0;
    core(NB, 2, 1, 1, 1); drain(2, 1);
    check_result("s6", NB, 0);
    @(negedge clock_i);

    for (int it = 0; it < 20; it++) begin
      int nc;
      nc = $urandom_range(0, 6);
      random_msg(); clear_rec();
      send_all(1);
      core(nc, $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1);
      drain(2, 0);
      check_result("rnd", (nc < NB) ? nc : NB, nc != NB);
      @(negedge clock_i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: time %0t reached without completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
